// File: rtl/div64_if.sv
// Request/response bundle for the iterative divider.
// Valid/ready on both the request and the result side.
interface div64_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] Result;

  modport master (
    output in_valid, op, A, B, flush, out_ready,
    input  in_ready, out_valid, Result
  );

  modport slave (
    input  in_valid, op, A, B, flush, out_ready,
    output in_ready, out_valid, Result
  );
endinterface

// File: rtl/div64_iter.sv
// Restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle; B==0 and signed overflow finish in one.
module div64_iter #(
  parameter int XLEN = 64
) (
  input logic    clk,
  input logic    rst_n,
  div64_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} st_t;

  st_t             st, nst;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem, quo, bm, res;
  logic            isrem, negq, negr;

  logic            fire, sgn, ovf, spec;
  logic [XLEN-1:0] am_in, bm_in, sres;
  logic [XLEN:0]   rw;
  logic            ge;
  logic [XLEN-1:0] rem_n, quo_n, fin;

  // Request decode: magnitudes and the one-cycle special results.
  always_comb begin
    sgn   = ~bus.op[0];
    fire  = bus.in_valid & (st == IDLE) & ~bus.flush;
    am_in = (sgn & bus.A[XLEN-1]) ? -bus.A : bus.A;
    bm_in = (sgn & bus.B[XLEN-1]) ? -bus.B : bus.B;
    ovf   = sgn & (bus.A == SMIN) & (bus.B == '1);
    spec  = (bus.B == '0) | ovf;
    if (ovf)
      sres = bus.op[1] ? '0 : bus.A;
    else
      sres = bus.op[1] ? bus.A : '1;
  end

  // One restoring step plus the sign fixup of the final step.
  always_comb begin
    rw    = {rem, quo[XLEN-1]};
    ge    = rw >= {1'b0, bm};
    rem_n = ge ? rw[XLEN-1:0] - bm : rw[XLEN-1:0];
    quo_n = {quo[XLEN-2:0], ge};
    if (isrem)
      fin = negr ? -rem_n : rem_n;
    else
      fin = negq ? -quo_n : quo_n;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= nst;
  end

  // Next state; flush wins over everything.
  always_comb begin
    nst = st;
    unique case (st)
      IDLE: if (fire) nst = spec ? DONE : CALC;
      CALC: if (cnt == '0) nst = DONE;
      DONE: if (bus.out_ready) nst = IDLE;
      default: nst = IDLE;
    endcase
    if (bus.flush) nst = IDLE;
  end

  // Outputs decoded from state.
  always_comb begin
    bus.in_ready  = (st == IDLE);
    bus.out_valid = (st == DONE);
    bus.Result    = res;
  end

  // Operand latch and the shift/subtract datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      bm    <= '0;
      res   <= '0;
      isrem <= 1'b0;
      negq  <= 1'b0;
      negr  <= 1'b0;
    end else if (fire) begin
      isrem <= bus.op[1];
      negq  <= sgn & (bus.A[XLEN-1] ^ bus.B[XLEN-1]);
      negr  <= sgn & bus.A[XLEN-1];
      rem   <= '0;
      quo   <= am_in;
      bm    <= bm_in;
      cnt   <= CW'(XLEN - 1);
      if (spec) res <= sres;
    end else if (st == CALC && !bus.flush) begin
      rem <= rem_n;
      quo <= quo_n;
      cnt <= cnt - CW'(1);
      if (cnt == '0) res <= fin;
    end
  end
endmodule

// File: tb/tb_div64_iter.sv
// Bench for div64_iter: directed table, random ops vs model,
// backpressure, flush and async reset sequences.
module tb_div64_iter;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = '1;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  div64_if #(.XLEN(64)) bus ();

  div64_iter #(.XLEN(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic special(input logic [1:0] o,
                                   input logic [63:0] a,
                                   input logic [63:0] b);
    return (b == 0) || (!o[0] && a == MIN && b == ONES);
  endfunction

  function automatic logic [63:0] model(input logic [1:0] o,
                                        input logic [63:0] a,
                                        input logic [63:0] b);
    logic signed [63:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return o[1] ? a : ONES;
    if (!o[0] && a == MIN && b == ONES) return o[1] ? 64'd0 : a;
    case (o)
      2'd0:    return sa / sb;
      2'd1:    return a / b;
      2'd2:    return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  // Issue one request; returns the result and the number of
  // edges from the accept edge (counted as 1) to out_valid.
  task automatic issue(input logic [1:0] o,
                       input logic [63:0] a,
                       input logic [63:0] b,
                       output logic [63:0] res,
                       output int lat);
    int t;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.A = a;
    bus.B = b;
    @(negedge clk);
    lat = 1;
    bus.in_valid = 1'b0;
    bus.op = 2'($urandom);
    bus.A = r64();
    bus.B = r64();
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = bus.Result;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vec_t        tv[$];
    logic [63:0] res;
    logic [63:0] a, b;
    logic [1:0]  o;
    int          lat, bad;

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.op = 2'd0;
    bus.A = '0;
    bus.B = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;

    tv.push_back('{2'd1, 64'd100, 64'd7, 64'd14, 65});
    tv.push_back('{2'd3, 64'd100, 64'd7, 64'd2, 65});
    tv.push_back('{2'd0, -64'd7, 64'd2, -64'd3, 65});
    tv.push_back('{2'd2, -64'd7, 64'd2, ONES, 65});
    tv.push_back('{2'd0, MIN, ONES, MIN, 1});
    tv.push_back('{2'd2, MIN, ONES, 64'd0, 1});
    tv.push_back('{2'd1, 64'd5, 64'd0, ONES, 1});
    tv.push_back('{2'd2, 64'd5, 64'd0, 64'd5, 1});
    tv.push_back('{2'd0, 64'd5, 64'd0, ONES, 1});
    tv.push_back('{2'd3, 64'd5, 64'd0, 64'd5, 1});
    tv.push_back('{2'd0, 64'd7, -64'd2, -64'd3, 65});
    tv.push_back('{2'd2, 64'd7, -64'd2, 64'd1, 65});
    tv.push_back('{2'd1, MIN, ONES, 64'd0, 65});
    tv.push_back('{2'd3, MIN, ONES, MIN, 65});
    tv.push_back('{2'd1, ONES, 64'd1, ONES, 65});
    tv.push_back('{2'd0, MIN, 64'd1, MIN, 65});

    #1;
    chk("rst in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst Result", bus.Result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tv[i]) begin
      chk($sformatf("v%0d in_ready", i), 64'(bus.in_ready), 64'd1);
      issue(tv[i].op, tv[i].a, tv[i].b, res, lat);
      chk($sformatf("v%0d result", i), res, tv[i].exp);
      chk($sformatf("v%0d latency", i), 64'(lat), 64'(tv[i].lat));
      take();
      chk($sformatf("v%0d released", i), 64'(bus.out_valid), 64'd0);
    end

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = r64();
      case ($urandom % 8)
        0:       b = 64'd0;
        1:       b = ONES;
        2:       b = 64'($urandom_range(1, 15));
        3:       b = 64'($urandom);
        default: b = r64();
      endcase
      if ($urandom % 6 == 0) a = MIN;
      issue(o, a, b, res, lat);
      chk($sformatf("rnd%0d op%0d result", i, o), res, model(o, a, b));
      chk($sformatf("rnd%0d latency", i), 64'(lat),
          special(o, a, b) ? 64'd1 : 64'd65);
      take();
    end

    // Backpressure in DONE.
    issue(2'd1, 64'd100, 64'd7, res, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.in_ready || bus.Result != 64'd14)
        bad++;
    end
    chk("bp stable", 64'(bad), 64'd0);
    take();
    chk("bp idle in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp idle out_valid", 64'(bus.out_valid), 64'd0);

    // Flush at cycle 30 of CALC.
    bus.in_valid = 1'b1;
    bus.op = 2'd1;
    bus.A = 64'd1000;
    bus.B = 64'd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (29) @(negedge clk);
    chk("calc busy", 64'(bus.in_ready), 64'd0);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush in_ready", 64'(bus.in_ready), 64'd1);
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.out_valid) bad++;
    end
    chk("flush no output", 64'(bad), 64'd0);

    // Flush with a request in IDLE: not accepted.
    bus.in_valid = 1'b1;
    bus.op = 2'd1;
    bus.A = 64'd5;
    bus.B = 64'd0;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    chk("idle flush out_valid", 64'(bus.out_valid), 64'd0);
    chk("idle flush in_ready", 64'(bus.in_ready), 64'd1);

    // Flush beats out_ready in DONE.
    issue(2'd1, 64'd9, 64'd0, res, lat);
    chk("pre drop result", res, ONES);
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.flush = 1'b0;
    chk("drop out_valid", 64'(bus.out_valid), 64'd0);
    chk("drop in_ready", 64'(bus.in_ready), 64'd1);

    // Async reset mid-CALC.
    issue(2'd1, 64'd100, 64'd7, res, lat);
    take();
    bus.in_valid = 1'b1;
    bus.op = 2'd0;
    bus.A = 64'd12345;
    bus.B = 64'd11;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst in_ready", 64'(bus.in_ready), 64'd1);
    chk("arst out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst Result", bus.Result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.out_valid) bad++;
    end
    chk("arst no output", 64'(bad), 64'd0);

    issue(2'd3, 64'd100, 64'd7, res, lat);
    chk("post reset result", res, 64'd2);
    chk("post reset latency", 64'(lat), 64'd65);
    take();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
